// File: rtl/caf_shift_sched.sv
// caf_shift_sched: sweeps lags 0..num_shifts-1, streaming ref[k]/rx[s+k] pairs plus one flush beat into
// the dot-product engine and presenting each lag's result tagged with s. Optional macro: CAF_SCHED_CONJ_EN.
module caf_shift_sched #(
    parameter int data_bits  = 12,
    parameter int length     = 5,
    parameter int addr_bits  = 10,
    parameter int shift_bits = 8,
    parameter int sum_bits   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [shift_bits-1:0] num_shifts,
    output logic                  busy,
    output logic                  done,
    output logic                  ref_rd_en,
    output logic [addr_bits-1:0]  ref_addr,
    output logic                  rx_rd_en,
    output logic [addr_bits-1:0]  rx_addr,
    input  logic [data_bits-1:0]  ref_i,
    input  logic [data_bits-1:0]  ref_q,
    input  logic [data_bits-1:0]  rx_i,
    input  logic [data_bits-1:0]  rx_q,
    output logic                  dot_x_tvalid,
    output logic                  dot_y_tvalid,
    output logic [data_bits-1:0]  dot_xi,
    output logic [data_bits-1:0]  dot_xq,
    output logic [data_bits-1:0]  dot_yi,
    output logic [data_bits-1:0]  dot_yq,
    output logic                  dot_tready,
    input  logic                  dot_valid,
    input  logic [sum_bits-1:0]   dot_i,
    input  logic [sum_bits-1:0]   dot_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [sum_bits-1:0]   out_i,
    output logic [sum_bits-1:0]   out_q,
    output logic [shift_bits-1:0] out_shift
);
    localparam int k_bits = length > 1 ? $clog2(length) : 1;

    typedef enum logic [2:0] {IDLE, FEED, FLUSH, WAIT, OUT, FIN} state_t;

    state_t                state_q, state_d;
    logic [k_bits-1:0]     k_q, k_d;
    logic [shift_bits-1:0] s_q, s_d, num_q, num_d, out_shift_q, out_shift_d;
    logic [sum_bits-1:0]   out_i_q, out_i_d, out_q_q, out_q_d;
    logic                  busy_q, busy_d, out_valid_q, out_valid_d;
    logic                  rd_q, flush_q;
    logic                  feed, last_k;
    logic [data_bits-1:0]  ref_q_adj;

`ifdef CAF_SCHED_CONJ_EN
    localparam logic [data_bits-1:0] most_neg = {1'b1, {(data_bits-1){1'b0}}};
    // Saturate the one value whose negation does not fit.
    assign ref_q_adj = (ref_q == most_neg) ? ~most_neg : -ref_q;
`else
    assign ref_q_adj = ref_q;
`endif

    assign feed   = state_q == FEED;
    assign last_k = k_q == k_bits'(length - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            s_q         <= '0;
            num_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_shift_q <= '0;
            rd_q        <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            s_q         <= s_d;
            num_q       <= num_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_shift_q <= out_shift_d;
            rd_q        <= feed;
            flush_q     <= state_q == FLUSH;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        s_d         = s_q;
        num_d       = num_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_shift_d = out_shift_q;
        case (state_q)
            IDLE: if (start) begin
                num_d = num_shifts;
                s_d   = '0;
                k_d   = '0;
                if (num_shifts == '0) begin
                    state_d = FIN;
                end else begin
                    busy_d  = 1'b1;
                    state_d = FEED;
                end
            end
            FEED: begin
                k_d = k_q + 1'b1;
                if (last_k) state_d = FLUSH;
            end
            FLUSH: state_d = WAIT;
            WAIT: if (dot_valid) begin
                out_i_d     = dot_i;
                out_q_d     = dot_q;
                out_shift_d = s_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: if (out_ready) begin
                out_valid_d = 1'b0;
                s_d         = s_q + 1'b1;
                k_d         = '0;
                state_d     = (s_d == num_q) ? FIN : FEED;
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign done       = state_q == FIN;
    assign ref_rd_en  = feed;
    assign rx_rd_en   = feed;
    assign ref_addr   = feed ? addr_bits'(k_q) : '0;
    assign rx_addr    = feed ? addr_bits'(s_q) + addr_bits'(k_q) : '0;
    assign dot_tready = feed || state_q == FLUSH || state_q == WAIT;

    // Data beats land one cycle after each read; the flush beat trails them with zero operands.
    assign dot_x_tvalid = rd_q | flush_q;
    assign dot_y_tvalid = rd_q | flush_q;
    assign dot_xi       = rd_q ? rx_i : '0;
    assign dot_xq       = rd_q ? rx_q : '0;
    assign dot_yi       = rd_q ? ref_i : '0;
    assign dot_yq       = rd_q ? ref_q_adj : '0;

    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_shift = out_shift_q;
endmodule

// File: tb/tb_caf_shift_sched.sv
// tb_caf_shift_sched: randomized sweeps against RAM and dot-product engine models, results checked
// against a direct lag-sum reference computed from the RAM contents.
module tb_caf_shift_sched;
    localparam int DB = 12, LEN = 5, AB = 3, SHB = 8, SUMB = 24, DEPTH = 1 << AB, LAT = 3;
    localparam int AOW = 4 + 2*AB + 2 + 4*DB + 2 + 2*SUMB + SHB;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0, inj = 1'b0;
    logic [SHB-1:0] num_shifts = '0;
    logic busy, done, ref_rd_en, rx_rd_en, dot_x_tvalid, dot_y_tvalid, dot_tready, dot_valid, out_valid;
    logic [AB-1:0] ref_addr, rx_addr;
    logic [DB-1:0] ref_i, ref_q, rx_i, rx_q, dot_xi, dot_xq, dot_yi, dot_yq;
    logic [SUMB-1:0] dot_i, dot_q, out_i, out_q;
    logic [SHB-1:0] out_shift;
    logic [AOW-1:0] all_out;

    always #5 clk = ~clk;

    caf_shift_sched #(.data_bits(DB), .length(LEN), .addr_bits(AB), .shift_bits(SHB), .sum_bits(SUMB)) dut (
        .clk(clk), .rst(rst), .start(start), .num_shifts(num_shifts), .busy(busy), .done(done),
        .ref_rd_en(ref_rd_en), .ref_addr(ref_addr), .rx_rd_en(rx_rd_en), .rx_addr(rx_addr),
        .ref_i(ref_i), .ref_q(ref_q), .rx_i(rx_i), .rx_q(rx_q),
        .dot_x_tvalid(dot_x_tvalid), .dot_y_tvalid(dot_y_tvalid), .dot_xi(dot_xi), .dot_xq(dot_xq),
        .dot_yi(dot_yi), .dot_yq(dot_yq), .dot_tready(dot_tready), .dot_valid(dot_valid),
        .dot_i(dot_i), .dot_q(dot_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .out_shift(out_shift)
    );

    assign all_out = {busy, done, ref_rd_en, rx_rd_en, ref_addr, rx_addr, dot_x_tvalid, dot_y_tvalid,
                      dot_xi, dot_xq, dot_yi, dot_yq, dot_tready, out_valid, out_i, out_q, out_shift};

    int checks = 0, failures = 0;

    // Sample RAMs with one-cycle read latency
    logic signed [DB-1:0] ref_mi[DEPTH], ref_mq[DEPTH], rx_mi[DEPTH], rx_mq[DEPTH];
    always @(posedge clk) begin
        if (ref_rd_en) begin
            ref_i <= ref_mi[ref_addr];
            ref_q <= ref_mq[ref_addr];
        end
        if (rx_rd_en) begin
            rx_i <= rx_mi[rx_addr];
            rx_q <= rx_mq[rx_addr];
        end
    end

    // Dot-product engine: complex MAC over LEN+1 beats, result after LAT cycles
    int acc_i, acc_q, beats, res_i, res_q;
    bit fire;
    logic [LAT-1:0] lat_v;
    logic [SUMB-1:0] lat_i[LAT], lat_q[LAT];
    always @(posedge clk) begin
        if (rst) begin
            acc_i = 0; acc_q = 0; beats = 0;
            lat_v <= '0;
        end else begin
            fire = 0;
            if (dot_x_tvalid) begin
                acc_i += $signed(dot_xi) * $signed(dot_yi) - $signed(dot_xq) * $signed(dot_yq);
                acc_q += $signed(dot_xi) * $signed(dot_yq) + $signed(dot_xq) * $signed(dot_yi);
                beats++;
                if (beats == LEN + 1) begin
                    fire = 1; res_i = acc_i; res_q = acc_q;
                    acc_i = 0; acc_q = 0; beats = 0;
                end
            end
            lat_v <= {lat_v[LAT-2:0], fire};
            lat_i[0] <= SUMB'(res_i);
            lat_q[0] <= SUMB'(res_q);
            for (int i = 1; i < LAT; i++) begin
                lat_i[i] <= lat_i[i-1];
                lat_q[i] <= lat_q[i-1];
            end
        end
    end
    assign dot_valid = lat_v[LAT-1] | inj;
    assign dot_i = lat_i[LAT-1];
    assign dot_q = lat_q[LAT-1];

    // Monitor
    int rd_ref[$], rd_rx[$], out_sh[$];
    logic [2*SUMB-1:0] out_res[$];
    int done_cnt = 0, strobe_err = 0;
    always @(negedge clk) begin
        if (ref_rd_en) begin
            rd_ref.push_back(int'(ref_addr));
            rd_rx.push_back(int'(rx_addr));
        end
        if (ref_rd_en !== rx_rd_en || dot_x_tvalid !== dot_y_tvalid) strobe_err++;
        if (out_valid && out_ready) begin
            out_sh.push_back(int'(out_shift));
            out_res.push_back({out_i, out_q});
        end
        if (done) done_cnt++;
    end

    function automatic logic [2*SUMB-1:0] exp_lag(int s);
        int si = 0, sq = 0, yq, a;
        for (int k = 0; k < LEN; k++) begin
            a = (s + k) % DEPTH;
            yq = ref_mq[k];
`ifdef CAF_SCHED_CONJ_EN
            yq = (yq == -(1 << (DB-1))) ? (1 << (DB-1)) - 1 : -yq;
`endif
            si += rx_mi[a] * ref_mi[k] - rx_mq[a] * yq;
            sq += rx_mi[a] * yq + rx_mq[a] * ref_mi[k];
        end
        return {SUMB'(si), SUMB'(sq)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(int mode);
        for (int a = 0; a < DEPTH; a++) begin
            ref_mi[a] = mode == 0 ? DB'(1) : mode == 1 ? DB'(0) : DB'($urandom);
            ref_mq[a] = mode == 0 ? DB'(0) : mode == 1 ? DB'(1) : DB'($urandom);
            rx_mi[a]  = mode == 0 ? DB'(1) : mode == 1 ? DB'(0) : DB'($urandom);
            rx_mq[a]  = mode == 0 ? DB'(0) : mode == 1 ? DB'(1) : DB'($urandom);
        end
    endtask

    task automatic clear_mon();
        rd_ref.delete(); rd_rx.delete(); out_sh.delete(); out_res.delete();
    endtask

    task automatic run_sweep(int n, bit rnd, output bit to);
        int d0 = done_cnt;
        clear_mon();
        num_shifts = SHB'(n);
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            if (done_cnt != d0) begin
                to = 1'b0;
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", all_out);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL idle_outputs got=%h want=0", all_out);
        end
    endtask

    task automatic test_basic();
        bit to;
        int d0 = done_cnt;
        fill(0);
        run_sweep(3, 0, to);
        checks++;
        if (to) begin failures++; $display("FAIL basic_timeout got=timeout want=done"); end
        checks++;
        if (out_sh.size() != 3) begin failures++; $display("FAIL basic_count got=%0d want=3", out_sh.size()); end
        for (int i = 0; i < out_sh.size() && i < 3; i++) begin
            checks++;
            if (out_sh[i] != i || out_res[i] !== {SUMB'(5), SUMB'(0)}) begin
                failures++;
                $display("FAIL basic_result[%0d] got shift=%0d iq=%h want shift=%0d iq=%h", i, out_sh[i], out_res[i], i, {SUMB'(5), SUMB'(0)});
            end
        end
        checks++;
        if (rd_rx.size() != 15) begin failures++; $display("FAIL basic_reads got=%0d want=15", rd_rx.size()); end
        for (int j = 0; j < rd_rx.size() && j < 15; j++) begin
            checks++;
            if (rd_ref[j] != j % LEN || rd_rx[j] != j / LEN + j % LEN) begin
                failures++;
                $display("FAIL basic_addr[%0d] got ref=%0d rx=%0d want ref=%0d rx=%0d", j, rd_ref[j], rd_rx[j], j % LEN, j / LEN + j % LEN);
            end
        end
        repeat (3) cyc();
        checks++;
        if (done_cnt != d0 + 1 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_done got=%0d busy=%b want=1 busy=0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_zero();
        int d0 = done_cnt;
        clear_mon();
        num_shifts = '0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL zero_done got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL zero_after got done=%b out_valid=%b want 0 0", done, out_valid);
        end
        checks++;
        if (rd_ref.size() != 0 || out_sh.size() != 0 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL zero_activity got reads=%0d outs=%0d dones=%0d want 0 0 1", rd_ref.size(), out_sh.size(), done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        logic [2*SUMB+SHB-1:0] snap;
        int d0 = done_cnt;
        fill(2);
        clear_mon();
        num_shifts = SHB'(2);
        out_ready = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 100 && !out_valid; c++) cyc();
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_first got out_valid=%b want 1", out_valid); end
        snap = {out_i, out_q, out_shift};
        for (int c = 0; c < 20; c++) begin
            cyc();
            checks++;
            if ({out_valid, out_i, out_q, out_shift} !== {1'b1, snap} || ref_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b data=%h rd=%b want v=1 data=%h rd=0", c, out_valid, {out_i, out_q, out_shift}, ref_rd_en, snap);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && done_cnt == d0; c++) cyc();
        checks++;
        if (out_sh.size() != 2) begin failures++; $display("FAIL bp_count got=%0d want=2", out_sh.size()); end
        for (int i = 0; i < out_sh.size() && i < 2; i++) begin
            checks++;
            if (out_sh[i] != i || out_res[i] !== exp_lag(i)) begin
                failures++;
                $display("FAIL bp_result[%0d] got shift=%0d iq=%h want shift=%0d iq=%h", i, out_sh[i], out_res[i], i, exp_lag(i));
            end
        end
    endtask

    task automatic test_sweep_random(int n, bit rnd, string tag);
        bit to;
        run_sweep(n, rnd, to);
        checks++;
        if (to) begin failures++; $display("FAIL %s_timeout got=timeout want=done", tag); end
        checks++;
        if (out_sh.size() != n || rd_rx.size() != n * LEN) begin
            failures++; $display("FAIL %s_count got outs=%0d reads=%0d want %0d %0d", tag, out_sh.size(), rd_rx.size(), n, n * LEN);
        end
        for (int i = 0; i < out_sh.size() && i < n; i++) begin
            checks++;
            if (out_sh[i] != i || out_res[i] !== exp_lag(i)) begin
                failures++;
                $display("FAIL %s_result[%0d] got shift=%0d iq=%h want shift=%0d iq=%h", tag, i, out_sh[i], out_res[i], i, exp_lag(i));
            end
        end
        for (int j = 0; j < rd_rx.size() && j < n * LEN; j++) begin
            checks++;
            if (rd_ref[j] != j % LEN || rd_rx[j] != (j / LEN + j % LEN) % DEPTH) begin
                failures++;
                $display("FAIL %s_addr[%0d] got ref=%0d rx=%0d want ref=%0d rx=%0d", tag, j, rd_ref[j], rd_rx[j], j % LEN, (j / LEN + j % LEN) % DEPTH);
            end
        end
    endtask

    task automatic test_wrap();
        int want[5] = '{6, 7, 0, 1, 2};
        fill(2);
        ref_mq[0] = {1'b1, {(DB-1){1'b0}}};
        test_sweep_random(8, 1, "wrap");
        for (int k = 0; k < LEN && 6 * LEN + k < rd_rx.size(); k++) begin
            checks++;
            if (rd_rx[6 * LEN + k] != want[k]) begin
                failures++; $display("FAIL wrap_s6[%0d] got=%0d want=%0d", k, rd_rx[6 * LEN + k], want[k]);
            end
        end
    endtask

    task automatic test_spurious();
        bit to;
        inj = 1'b1;
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL spur_idle got out_valid=%b want 0", out_valid); end
        inj = 1'b0;
        fill(2);
        clear_mon();
        num_shifts = SHB'(1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        inj = 1'b1;
        cyc();
        inj = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL spur_feed got out_valid=%b want 0", out_valid); end
        to = 1'b1;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (done) begin to = 1'b0; break; end
        end
        checks++;
        if (to || out_sh.size() != 1 || out_res[0] !== exp_lag(0)) begin
            failures++; $display("FAIL spur_result got outs=%0d timeout=%b want outs=1 correct sum", out_sh.size(), to);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        int d0;
        bit hit = 1'b0;
        fill(2);
        clear_mon();
        num_shifts = SHB'(3);
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (ref_rd_en && rx_addr == AB'(1) && ref_addr == AB'(0) && out_sh.size() == 1) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL rstmid_reach got=timeout want=feed_s1"); end
        cyc();
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin failures++; $display("FAIL rstmid_outputs got=%h want=0", all_out); end
        repeat (2) cyc();
        rst = 1'b0;
        repeat (2) cyc();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_done got dones=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
        test_sweep_random(2, 0, "rstmid_restart");
    endtask

    task automatic test_conj();
        bit to;
        logic [2*SUMB-1:0] want;
`ifdef CAF_SCHED_CONJ_EN
        want = {SUMB'(5), SUMB'(0)};
`else
        want = {SUMB'(-5), SUMB'(0)};
`endif
        fill(1);
        run_sweep(1, 0, to);
        checks++;
        if (to || out_sh.size() != 1) begin
            failures++; $display("FAIL conj_count got outs=%0d timeout=%b want 1 0", out_sh.size(), to);
        end else begin
            checks++;
            if (out_res[0] !== want) begin failures++; $display("FAIL conj_result got=%h want=%h", out_res[0], want); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_wrap();
        test_spurious();
        test_reset_mid();
        test_conj();
        for (int r = 0; r < 6; r++) begin
            fill(2);
            test_sweep_random($urandom_range(1, 9), 1'b1, "rand");
        end
        checks++;
        if (strobe_err != 0) begin failures++; $display("FAIL strobe_pairing got=%0d want=0", strobe_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
